// File: rtl/salu_pkg.sv
// Shared definitions for the sequential ALU: opcode map, FSM states, flag bit positions
// and the truth-table helper used by the bitwise logic unit.
package salu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_NOT  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_NAND = 4'h7;
    localparam logic [3:0] OP_NOR  = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    localparam int F_ZERO  = 0;
    localparam int F_CARRY = 1;
    localparam int F_OVF   = 2;
    localparam int F_DIV0  = 3;
    localparam int F_ERR   = 4;
    localparam int FLAG_W  = 5;

    // Two-input truth table indexed by {a_bit, b_bit}; NOT ignores b.
    function automatic logic [3:0] logic_lut(input logic [3:0] op);
        logic [3:0] lut;
        case (op)
            OP_NOT:  lut = 4'b0011;
            OP_AND:  lut = 4'b1000;
            OP_OR:   lut = 4'b1110;
            OP_NAND: lut = 4'b0111;
            OP_NOR:  lut = 4'b0001;
            OP_XOR:  lut = 4'b0110;
            default: lut = 4'b0000;
        endcase
        return lut;
    endfunction

endpackage

// File: rtl/seq_muldiv.sv
// Iterative unsigned engine: shift-add multiply or restoring divide, one bit per cycle.
// Result outputs show the value produced by the step in progress, valid when done=1.
module seq_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] quotient
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             div_reg;
    logic [WIDTH-1:0] acc_reg;   // product high half, or partial remainder
    logic [WIDTH-1:0] sh_reg;    // multiplier / dividend shifting out, result bits shifting in
    logic [WIDTH-1:0] opb_reg;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] sh_next;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_sub;

    always_comb begin
        mul_sum   = {1'b0, acc_reg} + (sh_reg[0] ? {1'b0, opb_reg} : '0);
        rem_shift = {acc_reg, sh_reg[WIDTH-1]};
        rem_sub   = rem_shift - {1'b0, opb_reg};
        if (div_reg) begin
            // Remainder stays below the divisor, so the WIDTH low bits are exact.
            if (rem_shift >= {1'b0, opb_reg}) begin
                acc_next = rem_sub[WIDTH-1:0];
                sh_next  = {sh_reg[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = rem_shift[WIDTH-1:0];
                sh_next  = {sh_reg[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = mul_sum[WIDTH:1];
            sh_next  = {mul_sum[0], sh_reg[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            div_reg <= 1'b0;
            acc_reg <= '0;
            sh_reg  <= '0;
            opb_reg <= '0;
        end else if (start) begin
            cnt_reg <= CNT_W'(WIDTH);
            div_reg <= is_div;
            acc_reg <= '0;
            sh_reg  <= a;
            opb_reg <= b;
        end else if (busy) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
            acc_reg <= acc_next;
            sh_reg  <= sh_next;
        end
    end

    assign busy       = (cnt_reg != '0);
    assign done       = (cnt_reg == CNT_W'(1));
    assign product_hi = acc_next;
    assign product_lo = sh_next;
    assign quotient   = sh_next;

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: single-cycle ops and flags computed here, MUL/DIV delegated
// to seq_muldiv; every result is held in DONE until the consumer takes it.
module seq_alu
    import salu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [4:0]       flags
);
    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  result_reg, result_next;
    logic [FLAG_W-1:0] flags_reg, flags_next;

    logic              accept;
    logic              eng_start;
    logic              eng_busy;
    logic              eng_done;
    logic [WIDTH-1:0]  eng_hi;
    logic [WIDTH-1:0]  eng_lo;
    logic [WIDTH-1:0]  eng_quot;

    logic [3:0]        lut;
    logic [WIDTH-1:0]  logic_res;
    logic [WIDTH:0]    sum;
    logic [WIDTH:0]    diff;
    logic [WIDTH-1:0]  sc_res;
    logic [FLAG_W-1:0] sc_flags;
    logic              sc_legal;

    assign in_ready  = (state_reg == IDLE) && !eng_busy;
    assign out_valid = (state_reg == DONE);
    assign result    = result_reg;
    assign flags     = flags_reg;

    assign accept    = in_valid && in_ready;
    assign eng_start = accept && ((opcode == OP_MUL) ||
                                  ((opcode == OP_DIV) && (operand_b != '0)));

    seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (eng_start),
        .is_div     (opcode == OP_DIV),
        .a          (operand_a),
        .b          (operand_b),
        .busy       (eng_busy),
        .done       (eng_done),
        .product_hi (eng_hi),
        .product_lo (eng_lo),
        .quotient   (eng_quot)
    );

    // Bitwise ops share one per-bit truth-table lookup.
    assign lut = logic_lut(opcode);
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_logic
            assign logic_res[gi] = lut[{operand_a[gi], operand_b[gi]}];
        end
    endgenerate

    assign sum  = {1'b0, operand_a} + {1'b0, operand_b};
    assign diff = {1'b0, operand_a} - {1'b0, operand_b};

    always_comb begin
        sc_res   = '0;
        sc_flags = '0;
        sc_legal = 1'b1;
        case (opcode)
            OP_ADD: begin
                sc_res          = sum[WIDTH-1:0];
                sc_flags[F_CARRY] = sum[WIDTH];
                sc_flags[F_OVF] = (operand_a[WIDTH-1] == operand_b[WIDTH-1]) &&
                                  (sum[WIDTH-1] != operand_a[WIDTH-1]);
            end
            OP_SUB: begin
                sc_res          = diff[WIDTH-1:0];
                sc_flags[F_CARRY] = diff[WIDTH];
                sc_flags[F_OVF] = (operand_a[WIDTH-1] != operand_b[WIDTH-1]) &&
                                  (diff[WIDTH-1] != operand_a[WIDTH-1]);
            end
            // Only divide-by-zero reaches the single-cycle path.
            OP_DIV: begin
                sc_res           = '1;
                sc_flags[F_DIV0] = 1'b1;
            end
            OP_MUL: sc_res = '0;
            OP_NOT, OP_AND, OP_OR, OP_NAND, OP_NOR, OP_XOR: sc_res = logic_res;
            OP_SHL: begin
                sc_res            = {operand_a[WIDTH-2:0], 1'b0};
                sc_flags[F_CARRY] = operand_a[WIDTH-1];
            end
            OP_SHR: begin
                sc_res            = {1'b0, operand_a[WIDTH-1:1]};
                sc_flags[F_CARRY] = operand_a[0];
            end
            default: begin
                sc_legal        = 1'b0;
                sc_flags[F_ERR] = 1'b1;
            end
        endcase
        sc_flags[F_ZERO] = sc_legal && (sc_res == '0);
    end

    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        flags_next  = flags_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (opcode == OP_MUL) begin
                        state_next = MUL;
                    end else if (eng_start) begin
                        state_next = DIV;
                    end else begin
                        state_next  = DONE;
                        result_next = sc_res;
                        flags_next  = sc_flags;
                    end
                end
            end
            MUL: begin
                if (eng_done) begin
                    state_next          = DONE;
                    result_next         = eng_lo;
                    flags_next          = '0;
                    flags_next[F_CARRY] = (eng_hi != '0);
                    flags_next[F_OVF]   = (eng_hi != '0);
                    flags_next[F_ZERO]  = (eng_lo == '0);
                end
            end
            DIV: begin
                if (eng_done) begin
                    state_next         = DONE;
                    result_next        = eng_quot;
                    flags_next         = '0;
                    flags_next[F_ZERO] = (eng_quot == '0);
                end
            end
            DONE: begin
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            result_reg <= '0;
            flags_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            flags_reg  <= flags_next;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed bench for seq_alu (WIDTH=8) against an arithmetic reference model.
module tb_seq_alu;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   opcode;
    logic [W-1:0] operand_a;
    logic [W-1:0] operand_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [4:0]   flags;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic; flags = {err, div0, ovf, carry, zero}.
    function automatic void model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] res, output logic [4:0] flg, output int lat);
        int ua = int'(a);
        int ub = int'(b);
        int sa = (ua >= 128) ? ua - 256 : ua;
        int sb = (ub >= 128) ? ub - 256 : ub;
        int s;
        bit c = 0, o = 0, d0 = 0, er = 0, legal = 1;
        lat = 1;
        res = 8'h00;
        case (op)
            4'h0: begin s = ua + ub; res = 8'(s); c = (s > 255); o = (sa + sb > 127) || (sa + sb < -128); end
            4'h1: begin res = 8'(ua - ub); c = (ua < ub); o = (sa - sb > 127) || (sa - sb < -128); end
            4'h2: begin s = ua * ub; res = 8'(s); c = (s > 255); o = c; lat = W + 1; end
            4'h3: begin
                if (ub == 0) begin res = 8'hFF; d0 = 1; end
                else begin res = 8'(ua / ub); lat = W + 1; end
            end
            4'h4: res = ~a;
            4'h5: res = a & b;
            4'h6: res = a | b;
            4'h7: res = ~(a & b);
            4'h8: res = ~(a | b);
            4'h9: res = a ^ b;
            4'hA: begin res = 8'(ua * 2); c = (ua >= 128); end
            4'hB: begin res = 8'(ua / 2); c = (ua % 2 == 1); end
            default: begin er = 1; legal = 0; end
        endcase
        flg = {er, d0, o, c, legal && (res == 8'h00)};
    endfunction

    // One request/response; hold = cycles of out_ready=0 after out_valid, poke = push a
    // competing request during that backpressure window.
    task automatic run(input string tag, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input int hold, input bit poke);
        logic [7:0] exp_res;
        logic [4:0] exp_flg;
        int         exp_lat;
        int         lat;
        bit         busy_ok;
        model(op, a, b, exp_res, exp_flg, exp_lat);
        @(negedge clk);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        opcode    = op;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        opcode    = 4'($urandom);
        operand_a = 8'($urandom);
        operand_b = 8'($urandom);
        lat     = 1;
        busy_ok = 1;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_ok = 0;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busy_not_ready"}, 32'(busy_ok), 32'd1);
        check({tag, "_done_not_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_result"}, 32'(result), 32'(exp_res));
        check({tag, "_flags"}, 32'(flags), 32'(exp_flg));
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                in_valid  = 1'b1;
                opcode    = 4'h0;
                operand_a = 8'h11;
                operand_b = 8'h22;
            end
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_result"}, 32'({flags, result}), 32'({exp_flg, exp_res}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_released"}, 32'({in_ready, out_valid}), 32'b10);
        if (poke) begin
            @(posedge clk);
            #1;
            check({tag, "_not_queued"}, 32'(out_valid), 32'd0);
        end
        $display("txn %s op=%h a=%h b=%h res=%h flags=%b lat=%0d", tag, op, a, b, result, flags, lat);
    endtask

    initial begin
        bit saw_valid;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        opcode    = 4'h0;
        operand_a = '0;
        operand_b = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_state", 32'({in_ready, out_valid, flags, result}), 32'({1'b1, 1'b0, 5'b0, 8'h00}));

        run("add_wrap", 4'h0, 8'hFF, 8'h01, 0, 0);
        run("sub_ovf",  4'h1, 8'h80, 8'h01, 0, 0);
        run("mul",      4'h2, 8'h10, 8'h11, 0, 0);
        run("div",      4'h3, 8'd200, 8'd7, 0, 0);
        run("div0",     4'h3, 8'h55, 8'h00, 0, 0);
        run("illegal",  4'hD, 8'h12, 8'h34, 0, 0);
        run("xor_bp",   4'h9, 8'hA5, 8'h0F, 5, 1);

        // Abort a multiply mid-flight; no result may ever appear for it.
        @(negedge clk);
        in_valid  = 1'b1;
        opcode    = 4'h2;
        operand_a = 8'h10;
        operand_b = 8'h11;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        saw_valid = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1;
        end
        check("abort_no_valid", 32'(saw_valid), 32'd0);
        check("abort_state", 32'({in_ready, flags, result}), 32'({1'b1, 5'b0, 8'h00}));
        run("shl_after_abort", 4'hA, 8'h81, 8'h00, 0, 0);

        for (int n = 0; n < 60; n++) begin
            logic [3:0] op;
            logic [7:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            run($sformatf("rnd%0d", n), op, a, b, $urandom_range(0, 2), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
